// File: rtl/cpri_tx_burst_framer_pkg.sv
// Shared types for the CPRI TX burst framer.
// Lane word, FIFO entry and burst FSM encoding.
package params_list_pkg;

    localparam int CPRI_RE_W         = 32;
    localparam int CPRI_WORD_W       = 64;
    localparam int CPRI_FIFO_DEPTH   = 128;
    localparam int CPRI_TX_BURST_LEN = 48;

    typedef logic [CPRI_WORD_W-1:0] cpri_word_t;

    typedef struct packed {
        logic       sym_last;
        cpri_word_t data;
    } tx_fifo_entry_t;

    typedef enum logic {
        TX_IDLE,
        TX_BURST
    } tx_state_e;

endpackage

// File: rtl/cpri_tx_burst_framer_if.sv
// CPRI TX framer bus: IQ RE stream in, lane word bursts out.
// master drives REs and strobes; slave is the framer.
interface cpri_tx_burst_framer_if #(
    parameter int RE_W   = 32,
    parameter int WORD_W = 64
);

    logic [RE_W-1:0]   i_re_data;
    logic              i_re_vld;
    logic              i_re_last;
    logic              o_re_rdy;
    logic              i_iq_tx_enable;
    logic [WORD_W-1:0] o_tx_data;
    logic              o_tx_vld;
    logic              o_tx_last;
    logic              o_tx_sym_last;

    modport master (
        output i_re_data,
        output i_re_vld,
        output i_re_last,
        input  o_re_rdy,
        output i_iq_tx_enable,
        input  o_tx_data,
        input  o_tx_vld,
        input  o_tx_last,
        input  o_tx_sym_last
    );

    modport slave (
        input  i_re_data,
        input  i_re_vld,
        input  i_re_last,
        output o_re_rdy,
        input  i_iq_tx_enable,
        output o_tx_data,
        output o_tx_vld,
        output o_tx_last,
        output o_tx_sym_last
    );

endinterface

// File: rtl/cpri_tx_burst_framer_word_fifo.sv
// Word FIFO for the CPRI TX framer: registered read,
// occupancy count, async active-low reset.
module cpri_tx_word_fifo
    import params_list_pkg::*;
#(
    parameter int  DEPTH = CPRI_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           push,
    input  tx_fifo_entry_t wr_entry,
    input  logic           pop,
    output tx_fifo_entry_t rd_entry,
    output logic           rd_vld,
    output logic [CW-1:0]  cnt
);

    tx_fifo_entry_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Read data is zeroed when idle so the lane bus rests at 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_entry <= '0;
            rd_vld   <= 1'b0;
            cnt      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            rd_vld   <= pop;
            rd_entry <= pop ? mem[rd_ptr] : '0;
            unique case (1'b1)
                push && !pop: cnt <= cnt + 1'b1;
                pop && !push: cnt <= cnt - 1'b1;
                default:      cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/cpri_tx_burst_framer.sv
// CPRI TX burst framer: packs IQ REs into lane words, emits bursts.
// CPRI_TX_STATS_EN adds saturating burst/underrun/overlap counters.
module cpri_tx_burst_framer
    import params_list_pkg::*;
#(
    parameter int  RE_W       = CPRI_RE_W,
    parameter int  WORD_W     = CPRI_WORD_W,
    parameter int  FIFO_DEPTH = CPRI_FIFO_DEPTH,
    parameter int  BURST_LEN  = CPRI_TX_BURST_LEN,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    cpri_tx_burst_framer_if.slave bus,
    output logic                  o_underrun,
    output logic                  o_overlap,
    output logic [CNT_W-1:0]      o_fifo_cnt
`ifdef CPRI_TX_STATS_EN
    ,
    output logic [31:0]           o_burst_cnt,
    output logic [15:0]           o_underrun_cnt,
    output logic [15:0]           o_overlap_cnt
`endif
);

    localparam int BC_W = $clog2(BURST_LEN);

    logic [1:0]        rst_sync_q;
    logic              rst_n_s;
    logic              re_acc;
    logic              half_q;
    logic [RE_W-1:0]   lo_q;
    logic [WORD_W-1:0] pair_word;
    logic [WORD_W-1:0] odd_word;
    logic              push_q;
    tx_fifo_entry_t    push_e_q;
    tx_fifo_entry_t    rd_e;
    logic              rd_vld;

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [BC_W-1:0]   bcnt_q;
    logic [BC_W-1:0]   bcnt_d;
    logic              pop;
    logic              start;
    logic              ur_d;
    logic              ov_d;
    logic              last_d;
    logic              last_q;

    // Assert asynchronously, release on the second clock edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) rst_sync_q <= '0;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_s = rst_sync_q[1];

    // Two words of headroom cover the push stage and an odd-RE flush.
    assign bus.o_re_rdy = rst_n_s &&
        (o_fifo_cnt <= CNT_W'(FIFO_DEPTH - 3));
    assign re_acc    = bus.i_re_vld & bus.o_re_rdy;
    assign pair_word = {bus.i_re_data, lo_q};
    assign odd_word  = {{RE_W{1'b0}}, bus.i_re_data};

    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            half_q   <= 1'b0;
            lo_q     <= '0;
            push_q   <= 1'b0;
            push_e_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (re_acc) begin
                if (half_q) begin
                    push_q            <= 1'b1;
                    push_e_q.data     <= pair_word;
                    push_e_q.sym_last <= bus.i_re_last;
                    half_q            <= 1'b0;
                end else if (bus.i_re_last) begin
                    push_q            <= 1'b1;
                    push_e_q.data     <= odd_word;
                    push_e_q.sym_last <= 1'b1;
                end else begin
                    lo_q   <= bus.i_re_data;
                    half_q <= 1'b1;
                end
            end
        end
    end

    cpri_tx_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (rst_n_s),
        .push      (push_q),
        .wr_entry  (push_e_q),
        .pop       (pop),
        .rd_entry  (rd_e),
        .rd_vld    (rd_vld),
        .cnt       (o_fifo_cnt)
    );

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        pop     = 1'b0;
        start   = 1'b0;
        ur_d    = 1'b0;
        ov_d    = 1'b0;
        last_d  = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (bus.i_iq_tx_enable) begin
                    if (o_fifo_cnt >= CNT_W'(BURST_LEN)) begin
                        state_d = TX_BURST;
                        bcnt_d  = '0;
                        start   = 1'b1;
                    end else begin
                        ur_d = 1'b1;
                    end
                end
            end
            TX_BURST: begin
                pop  = 1'b1;
                ov_d = bus.i_iq_tx_enable;
                if (bcnt_q == BC_W'(BURST_LEN - 1)) begin
                    state_d = TX_IDLE;
                    last_d  = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q    <= TX_IDLE;
            bcnt_q     <= '0;
            o_underrun <= 1'b0;
            o_overlap  <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            o_underrun <= ur_d;
            o_overlap  <= ov_d;
            last_q     <= last_d;
        end
    end

    assign bus.o_tx_data     = rd_e.data;
    assign bus.o_tx_sym_last = rd_e.sym_last;
    assign bus.o_tx_vld      = rd_vld;
    assign bus.o_tx_last     = last_q;

`ifdef CPRI_TX_STATS_EN
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            o_burst_cnt    <= '0;
            o_underrun_cnt <= '0;
            o_overlap_cnt  <= '0;
        end else begin
            if (start && (o_burst_cnt != '1))
                o_burst_cnt <= o_burst_cnt + 1'b1;
            if (ur_d && (o_underrun_cnt != '1))
                o_underrun_cnt <= o_underrun_cnt + 1'b1;
            if (ov_d && (o_overlap_cnt != '1))
                o_overlap_cnt <= o_overlap_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpri_tx_burst_framer.sv
// Scoreboard bench for cpri_tx_burst_framer.
// Expected words are queued on RE accept and popped on o_tx_vld.
module tb_cpri_tx_burst_framer;
    import params_list_pkg::*;

    localparam int BL = 48;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpri_tx_burst_framer_if bus ();

    logic       ur;
    logic       ov;
    logic [7:0] fcnt;
`ifdef CPRI_TX_STATS_EN
    logic [31:0] st_b;
    logic [15:0] st_u;
    logic [15:0] st_o;
`endif

    cpri_tx_burst_framer dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .bus            (bus),
        .o_underrun     (ur),
        .o_overlap      (ov),
        .o_fifo_cnt     (fcnt)
`ifdef CPRI_TX_STATS_EN
        ,
        .o_burst_cnt    (st_b),
        .o_underrun_cnt (st_u),
        .o_overlap_cnt  (st_o)
`endif
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    tx_fifo_entry_t exp_q[$];
    tx_fifo_entry_t mon_e;
    logic           half;
    logic [31:0]    lo;
    int             re_val;

    int          rx_words  = 0;
    int          first_cyc = -1;
    int          last_cyc  = -1;
    int          last_cnt  = 0;
    int          ur_cyc    = -1;
    int          ur_seen   = 0;
    int          ov_seen   = 0;
    int          sym_seen  = 0;
    int          bidx      = 0;
    logic [63:0] bw [64];
    int          m_bursts  = 0;
    int          m_ur      = 0;
    int          m_ov      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic void model_accept(input logic [31:0] d,
                                         input logic lst);
        tx_fifo_entry_t e;
        if (half) begin
            e.data = {d, lo}; e.sym_last = lst;
            exp_q.push_back(e); half = 1'b0;
        end else if (lst) begin
            e.data = {32'd0, d}; e.sym_last = 1'b1;
            exp_q.push_back(e);
        end else begin
            lo = d; half = 1'b1;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (ur) begin ur_cyc = cyc; ur_seen++; end
            if (ov) ov_seen++;
            if (bus.o_tx_vld) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (bidx < 64) bw[bidx] = bus.o_tx_data;
                bidx++;
                if (bus.o_tx_sym_last) sym_seen++;
                if (bus.o_tx_last) begin
                    last_cyc = cyc; last_cnt++;
                end
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("tx_data", bus.o_tx_data, mon_e.data);
                    chk("tx_sym_last", 64'(bus.o_tx_sym_last),
                        64'(mon_e.sym_last));
                end
                rx_words++;
            end else begin
                chk("idle_data", bus.o_tx_data, 64'd0);
            end
        end
    end

    task automatic send_res(input int n, input bit last_end);
        for (int i = 0; i < n; i++) begin
            logic acc;
            logic lst;
            int   w;
            lst = last_end && (i == n - 1);
            bus.i_re_data = re_val;
            bus.i_re_vld  = 1'b1;
            bus.i_re_last = lst;
            acc = 1'b0;
            w   = 0;
            while (!acc) begin
                @(negedge clk);
                acc = bus.o_re_rdy;
                @(posedge clk); #1;
                w++;
                if (!acc && w > 3000) begin
                    chk("re_stall_timeout", 64'(w), 64'd0);
                    bus.i_re_vld = 1'b0; bus.i_re_last = 1'b0;
                    return;
                end
            end
            model_accept(re_val, lst);
            re_val++;
        end
        bus.i_re_vld  = 1'b0;
        bus.i_re_last = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_burst(input int exp_w, input bit ovl);
        int t0, base, ur0, ov0, lc0;
        base = rx_words; ur0 = ur_seen; ov0 = ov_seen; lc0 = last_cnt;
        first_cyc = -1; last_cyc = -1; ur_cyc = -1; bidx = 0;
        @(posedge clk); #1;
        t0 = cyc;
        bus.i_iq_tx_enable = 1'b1;
        @(posedge clk); #1;
        bus.i_iq_tx_enable = 1'b0;
        if (ovl) begin
            repeat (9) @(posedge clk);
            #1 bus.i_iq_tx_enable = 1'b1;
            @(posedge clk);
            #1 bus.i_iq_tx_enable = 1'b0;
        end
        repeat (56) @(posedge clk);
        #1;
        chk("burst_words", 64'(rx_words - base), 64'(exp_w));
        chk("overlap_pulse", 64'(ov_seen - ov0), 64'(ovl));
        if (exp_w > 0) begin
            chk("first_lat", 64'(first_cyc - t0), 64'd2);
            chk("last_lat", 64'(last_cyc - t0), 64'(BL + 1));
            chk("last_count", 64'(last_cnt - lc0), 64'd1);
            chk("no_underrun", 64'(ur_seen - ur0), 64'd0);
            m_bursts++;
        end else begin
            chk("underrun_pulse", 64'(ur_seen - ur0), 64'd1);
            chk("underrun_lat", 64'(ur_cyc - t0), 64'd1);
            m_ur++;
        end
        if (ovl) m_ov++;
    endtask

`ifdef CPRI_TX_STATS_EN
    task automatic chk_stats();
        chk("stat_bursts", 64'(st_b), 64'(m_bursts));
        chk("stat_underrun", 64'(st_u), 64'(m_ur));
        chk("stat_overlap", 64'(st_o), 64'(m_ov));
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, base, sym0;
        rst_n = 1'b0;
        bus.i_re_data = '0; bus.i_re_vld = 1'b0;
        bus.i_re_last = 1'b0; bus.i_iq_tx_enable = 1'b0;
        half = 1'b0; lo = '0; re_val = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 64'(bus.o_tx_vld), 64'd0);
        chk("rst_data", bus.o_tx_data, 64'd0);
        chk("rst_rdy", 64'(bus.o_re_rdy), 64'd0);
        chk("rst_cnt", 64'(fcnt), 64'd0);
        chk("rst_underrun", 64'(ur), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rel_rdy", 64'(bus.o_re_rdy), 64'd1);
        chk("rel_cnt", 64'(fcnt), 64'd0);
        @(posedge clk); #1;

        // 96 REs 0..95, one full burst
        re_val = 0;
        send_res(96, 1'b0);
        settle();
        chk("b_cnt48", 64'(fcnt), 64'd48);
        do_burst(BL, 1'b0);
        chk("b_word0", bw[0], {32'd1, 32'd0});
        chk("b_word47", bw[47], {32'd95, 32'd94});
        settle();
        chk("b_cnt0", 64'(fcnt), 64'd0);

        // odd symbol, underrun at 47 words, overlap at burst cycle 10
        re_val = 100;
        send_res(3, 1'b1);
        re_val = 200;
        send_res(90, 1'b0);
        settle();
        chk("c_cnt47", 64'(fcnt), 64'd47);
        do_burst(0, 1'b0);
        chk("c_cnt_hold", 64'(fcnt), 64'd47);
        send_res(2, 1'b0);
        settle();
        chk("c_cnt48", 64'(fcnt), 64'd48);
        do_burst(BL, 1'b1);
        chk("c_word1", bw[1], {32'd0, 32'd102});
        chk("c_word2", bw[2], {32'd201, 32'd200});
        settle();
        chk("c_cnt0", 64'(fcnt), 64'd0);

        // fill until o_re_rdy drops, then drain
        re_val = 1000;
        fork
            send_res(260, 1'b0);
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (bus.o_re_rdy && k < 2000);
                chk("d_rdy_drop", 64'(bus.o_re_rdy), 64'd0);
                chk("d_cnt_at_drop", 64'(fcnt), 64'd126);
                repeat (5) @(negedge clk);
                chk("d_stall_cnt", 64'(fcnt), 64'd126);
                chk("d_stall_rdy", 64'(bus.o_re_rdy), 64'd0);
                do_burst(BL, 1'b0);
            end
        join
        settle();
        chk("d_cnt_left", 64'(fcnt), 64'(exp_q.size()));
        do_burst(BL, 1'b0);
        send_res(28, 1'b0);
        settle();
        do_burst(BL, 1'b0);
        settle();
        chk("d_cnt0", 64'(fcnt), 64'd0);

        // 1584-RE symbol streamed against repeated bursts
        re_val = 5000;
        sym0 = sym_seen;
        fork
            send_res(1584, 1'b1);
            begin
                for (int b = 0; b < 16; b++) begin
                    k = 0;
                    while (fcnt < 48 && k < 3000) begin
                        @(posedge clk); #1;
                        k++;
                    end
                    if (fcnt < 48) chk("e_wait", 64'(fcnt), 64'd48);
                    do_burst(BL, 1'b0);
                end
            end
        join
        settle();
        chk("e_cnt_left", 64'(fcnt), 64'(exp_q.size()));
        send_res(2 * (BL - exp_q.size()), 1'b0);
        settle();
        do_burst(BL, 1'b0);
        chk("e_sym_last_words", 64'(sym_seen - sym0), 64'd1);
        settle();
        chk("e_cnt0", 64'(fcnt), 64'd0);

`ifdef CPRI_TX_STATS_EN
        chk_stats();
`endif

        // reset dropped at burst word 20
        re_val = 0;
        send_res(96, 1'b0);
        settle();
        base = rx_words;
        bus.i_iq_tx_enable = 1'b1;
        @(posedge clk); #1;
        bus.i_iq_tx_enable = 1'b0;
        k = 0;
        while (rx_words - base < 20 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("f_reach20", 64'(rx_words - base), 64'd20);
        rst_n = 1'b0;
        #1;
        chk("f_vld", 64'(bus.o_tx_vld), 64'd0);
        chk("f_data", bus.o_tx_data, 64'd0);
        chk("f_last", 64'(bus.o_tx_last), 64'd0);
        chk("f_sym", 64'(bus.o_tx_sym_last), 64'd0);
        chk("f_cnt", 64'(fcnt), 64'd0);
        chk("f_rdy", 64'(bus.o_re_rdy), 64'd0);
        exp_q.delete();
        half = 1'b0;
        m_bursts = 0; m_ur = 0; m_ov = 0;
`ifdef CPRI_TX_STATS_EN
        chk_stats();
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("f_rel_rdy", 64'(bus.o_re_rdy), 64'd1);
        chk("f_rel_cnt", 64'(fcnt), 64'd0);
        @(posedge clk); #1;

        // clean burst after reset
        re_val = 0;
        send_res(96, 1'b0);
        settle();
        do_burst(BL, 1'b0);
        chk("g_word0", bw[0], {32'd1, 32'd0});
        settle();
        chk("g_cnt0", 64'(fcnt), 64'd0);
`ifdef CPRI_TX_STATS_EN
        chk_stats();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
